seg7_scan_capture: RTL and testbench

- Receive-side counterpart of the BCD-to-7-segment display drivers.
- Watches a 4-digit, common-anode, multiplexed display bus (active-low segments, decimal point and digit selects) and recovers each digit's BCD value, decimal-point state, validity and pattern-error status.
- Typical uses: self-check of a driver inside the FPGA, or capture of an external display's pins.
- Includes a per-dwell stability filter against ghosting, frame completion detection and a loss-of-scan timeout.

---
 rtl/seg7_scan_capture_if.sv | 27 ++
 rtl/seg7_scan_capture.sv | 159 +++++++++++++++
 tb/tb_seg7_scan_capture.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_capture_if.sv
// Display bus seen by seg7_scan_capture: the multiplexed common-anode pins
// (all active-low) plus the recovered per-digit results.
// master: whoever drives the display pins and reads the results.
// slave : the capture block.
// There is no valid/ready handshake on this bus. The pins are free-running
// levels, and the results are plain registered levels except frame_done,
// which is a single-cycle pulse.
interface seg7_scan_capture_if;
  logic [6:0]  Segments;
  logic        bp;
  logic [3:0]  SEL;
  logic [15:0] digits;
  logic [3:0]  dp;
  logic [3:0]  valid;
  logic [3:0]  err;
  logic        frame_done;

  modport master (
    output Segments, bp, SEL,
    input  digits, dp, valid, err, frame_done
  );

  modport slave (
    input  Segments, bp, SEL,
    output digits, dp, valid, err, frame_done
  );
endinterface

// File: rtl/seg7_scan_capture.sv
// seg7_scan_capture: watches a 4-digit multiplexed common-anode display bus
// and recovers each digit's BCD value, decimal point, validity and error
// status. A dwell is accepted once it has been sampled STABLE_CYCLES times in
// a row, and it is accepted only once. Frame completion is reported as a
// pulse. Valid bits clear after TIMEOUT_CYCLES cycles with no acceptance.
// Optional macro SEG7_CAP_HEX_EN: also decode A..F (10..15) as legal values.
module seg7_scan_capture #(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                clk50MHz,
  input  logic                rst_n,
  seg7_scan_capture_if.slave  bus
);

  localparam int RW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [RW-1:0] RUN_MAX = RW'(STABLE_CYCLES - 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES - 1);

  // Sampled pins, packed as {SEL, bp, Segments}. Reset value: everything inactive.
  logic [11:0]   r_in_q;
  logic [RW-1:0] r_run_cnt;
  logic          r_taken;     // the current dwell has already been accepted
  logic [TW-1:0] r_tmo_cnt;
  logic [3:0]    r_seen;
  logic [15:0]   r_digits;
  logic [3:0]    r_dp;
  logic [3:0]    r_valid;
  logic [3:0]    r_err;
  logic          r_frame_done;

  logic [11:0] w_pins;
  logic [3:0]  w_hit;         // active-high digit select taken from the dwell
  logic [6:0]  w_seg;
  logic        w_one_sel;
  logic        w_accept;
  logic        w_blank;
  logic        w_legal;
  logic [3:0]  w_val;

  assign w_pins    = {bus.SEL, bus.bp, bus.Segments};
  assign w_hit     = ~r_in_q[11:8];
  assign w_seg     = r_in_q[6:0];
  assign w_one_sel = (w_hit != 4'd0) && ((w_hit & (w_hit - 4'd1)) == 4'd0);
  assign w_accept  = (r_run_cnt == RUN_MAX) && w_one_sel && !r_taken;
  assign w_blank   = (w_seg == 7'h7F);

  // Map an active-low segment pattern to a digit value and flag legal codes.
  always_comb begin
    w_legal = 1'b1;
    w_val   = 4'h0;
    case (w_seg)
      7'h40: w_val = 4'h0;
      7'h79: w_val = 4'h1;
      7'h24: w_val = 4'h2;
      7'h30: w_val = 4'h3;
      7'h19: w_val = 4'h4;
      7'h12: w_val = 4'h5;
      7'h02: w_val = 4'h6;
      7'h78: w_val = 4'h7;
      7'h00: w_val = 4'h8;
      7'h10: w_val = 4'h9;
`ifdef SEG7_CAP_HEX_EN
      7'h08: w_val = 4'hA;
      7'h03: w_val = 4'hB;
      7'h46: w_val = 4'hC;
      7'h21: w_val = 4'hD;
      7'h06: w_val = 4'hE;
      7'h0E: w_val = 4'hF;
`endif
      default: w_legal = 1'b0;
    endcase
  end

  // Sample the pins and track how long the current dwell has been stable.
  // Any change in the pins starts a new dwell that has not been accepted yet.
  always_ff @(posedge clk50MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_in_q    <= 12'hFFF;
      r_run_cnt <= '0;
      r_taken   <= 1'b0;
    end else if (w_pins != r_in_q) begin
      r_in_q    <= w_pins;
      r_run_cnt <= '0;
      r_taken   <= 1'b0;
    end else begin
      if (r_run_cnt != RUN_MAX) r_run_cnt <= r_run_cnt + 1'b1;
      if (w_accept)             r_taken   <= 1'b1;
    end
  end

  // Update the selected digit on acceptance. Otherwise apply the timeout.
  // On an edge that has both, the acceptance takes priority.
  always_ff @(posedge clk50MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_digits <= '0;
      r_dp     <= '0;
      r_valid  <= '0;
      r_err    <= '0;
    end else if (w_accept) begin
      for (int i = 0; i < 4; i++) begin
        if (w_hit[i]) begin
          r_dp[i] <= ~r_in_q[7];
          if (w_blank) begin
            r_valid[i] <= 1'b0;
            r_err[i]   <= 1'b0;
          end else if (w_legal) begin
            r_digits[4*i +: 4] <= w_val;
            r_valid[i]         <= 1'b1;
            r_err[i]           <= 1'b0;
          end else begin
            r_valid[i] <= 1'b0;
            r_err[i]   <= 1'b1;
          end
        end
      end
    end else if (r_tmo_cnt == TMO_MAX) begin
      r_valid <= '0;
    end
  end

  // Collect accepted digits. The acceptance that completes the set pulses
  // frame_done and starts a new, empty set.
  always_ff @(posedge clk50MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_seen       <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (w_accept) begin
        if ((r_seen | w_hit) == 4'hF) begin
          r_seen       <= '0;
          r_frame_done <= 1'b1;
        end else begin
          r_seen <= r_seen | w_hit;
        end
      end
    end
  end

  // Count cycles since the last acceptance, saturating at the timeout value.
  always_ff @(posedge clk50MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo_cnt <= '0;
    end else if (w_accept) begin
      r_tmo_cnt <= '0;
    end else if (r_tmo_cnt != TMO_MAX) begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end

  assign bus.digits     = r_digits;
  assign bus.dp         = r_dp;
  assign bus.valid      = r_valid;
  assign bus.err        = r_err;
  assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Bench for seg7_scan_capture. Stimulus is a sequence of dwells, each a
// (pin value, length) pair. The reference model works one whole dwell at a
// time. A dwell lasting at least S cycles with exactly one select low is
// accepted S edges after it starts, and it updates the model's digit state at
// that edge. Outputs are compared on every falling edge.
module tb_seg7_scan_capture;
  localparam int S = 4;
  localparam int T = 200;
`ifdef SEG7_CAP_HEX_EN
  localparam int N_CODES = 16;
`else
  localparam int N_CODES = 10;
`endif

  logic clk50MHz = 1'b0;
  logic rst_n    = 1'b0;

  seg7_scan_capture_if bus();

  seg7_scan_capture #(.STABLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
    .clk50MHz (clk50MHz),
    .rst_n    (rst_n),
    .bus      (bus)
  );

  // clock
  always #10 clk50MHz = ~clk50MHz;

  int checks = 0;
  int errors = 0;
  int edge_no = 0;
  int last_acc = 0;
  logic [11:0] last_pins = 12'hFFF;

  // reference model state
  logic [15:0] m_digits;
  logic [3:0]  m_dp, m_valid, m_err, m_seen;
  logic        m_fd;
  int          ev_edge[$];
  logic [11:0] ev_val[$];

  logic [6:0] code_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s edge=%0d observed=%h expected=%h", tag, edge_no, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_digits = '0; m_dp = '0; m_valid = '0; m_err = '0; m_seen = '0; m_fd = 1'b0;
    ev_edge.delete(); ev_val.delete();
    edge_no = 0; last_acc = 0;
  endtask

  // Apply one accepted dwell to the model.
  task automatic m_accept(input logic [11:0] v);
    int idx;
    int val;
    idx = 0;
    val = -1;
    for (int i = 0; i < 4; i++) if (!v[8+i]) idx = i;
    for (int k = 0; k < N_CODES; k++) if (code_tab[k] == v[6:0]) val = k;
    m_dp[idx] = ~v[7];
    if (v[6:0] == 7'h7F) begin
      m_valid[idx] = 1'b0; m_err[idx] = 1'b0;
    end else if (val >= 0) begin
      m_digits[idx*4 +: 4] = 4'(val);
      m_valid[idx] = 1'b1; m_err[idx] = 1'b0;
    end else begin
      m_valid[idx] = 1'b0; m_err[idx] = 1'b1;
    end
    m_seen[idx] = 1'b1;
    if (m_seen == 4'hF) begin
      m_fd = 1'b1; m_seen = '0;
    end
    last_acc = edge_no;
  endtask

  task automatic compare_all();
    check("digits",     bus.digits,            m_digits);
    check("dp",         16'(bus.dp),           16'(m_dp));
    check("valid",      16'(bus.valid),        16'(m_valid));
    check("err",        16'(bus.err),          16'(m_err));
    check("frame_done", 16'(bus.frame_done),   16'(m_fd));
  endtask

  // One clock: drive pins (called at a falling edge), advance the model at
  // the rising edge, then compare at the next falling edge.
  task automatic tick(input logic [11:0] v);
    {bus.SEL, bus.bp, bus.Segments} = v;
    last_pins = v;
    @(posedge clk50MHz);
    edge_no++;
    m_fd = 1'b0;
    if (ev_edge.size() > 0 && ev_edge[0] == edge_no) begin
      m_accept(ev_val[0]);
      void'(ev_edge.pop_front());
      void'(ev_val.pop_front());
    end else if (edge_no - last_acc >= T) begin
      m_valid = '0;
    end
    @(negedge clk50MHz);
    compare_all();
  endtask

  function automatic bit one_low(input logic [3:0] sel);
    int n;
    n = 0;
    for (int i = 0; i < 4; i++) if (!sel[i]) n++;
    return n == 1;
  endfunction

  task automatic dwell(input logic [11:0] v, input int n);
    if (n >= S && one_low(v[11:8])) begin
      ev_edge.push_back(edge_no + 1 + S);
      ev_val.push_back(v);
    end
    for (int c = 0; c < n; c++) tick(v);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_digits"}, bus.digits, 16'h0000);
    check({tag, "_flags"}, {3'b000, bus.dp, bus.valid, bus.err, bus.frame_done}, 16'h0000);
  endtask

  logic [11:0] rv;
  logic [3:0]  rsel;
  logic [6:0]  rseg;
  int          rn, rk;

  initial begin
    // reset
    {bus.SEL, bus.bp, bus.Segments} = 12'hFFF;
    rst_n = 1'b0;
    model_reset();
    #25;
    check_reset_outputs("reset");
    @(negedge clk50MHz);
    rst_n = 1'b1;
    model_reset();

    // digit 0 shows 2 with decimal point lit, held 10 cycles
    dwell({4'b1110, 1'b0, 7'h24}, 10);
    check("tp_digit0", 16'(bus.digits[3:0]), 16'h2);
    check("tp_valid0", 16'(bus.valid), 16'h1);

    // digit 1: short 4 pattern is rejected, then 3 is accepted
    dwell({4'b1101, 1'b1, 7'h19}, 3);
    dwell({4'b1101, 1'b1, 7'h30}, 5);
    check("tp_digit1", 16'(bus.digits[7:4]), 16'h3);

    // scan 1,2,3,4 across digits 0..3
    dwell({4'b1110, 1'b1, 7'h79}, 4);
    dwell({4'b1101, 1'b1, 7'h24}, 4);
    dwell({4'b1011, 1'b1, 7'h30}, 4);
    dwell({4'b0111, 1'b1, 7'h19}, 4);

    // illegal pattern then blank on digit 2
    dwell({4'b1011, 1'b1, 7'h55}, 6);
    check("tp_scan", bus.digits, 16'h4321);
    check("tp_err2", 16'(bus.err), 16'h4);
    dwell({4'b1011, 1'b1, 7'h7F}, 6);
    check("tp_blank_err", 16'(bus.err), 16'h0);

    // two selects low: ignored
    dwell({4'b1100, 1'b1, 7'h24}, 20);

    // randomized dwells
    for (int d = 0; d < 60; d++) begin
      do begin
        rsel = ($urandom_range(0, 9) < 7) ? ~(4'b0001 << $urandom_range(0, 3)) : 4'($urandom);
        rk = $urandom_range(0, 18);
        if (rk < 16)       rseg = code_tab[rk];
        else if (rk == 16) rseg = 7'h7F;
        else               rseg = 7'($urandom);
        rv = {rsel, 1'($urandom), rseg};
      end while (rv == last_pins || rv == 12'hFFF);
      rn = $urandom_range(1, 8);
      dwell(rv, rn);
    end

    // stop scanning: valid clears after the timeout, digits hold
    dwell(12'hFFF, T + 20);
    check("tmo_valid", 16'(bus.valid), 16'h0);

    // asynchronous reset in the middle of a dwell
    tick({4'b1110, 1'b1, 7'h12});
    tick({4'b1110, 1'b1, 7'h12});
    @(posedge clk50MHz);
    #5;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    {bus.SEL, bus.bp, bus.Segments} = 12'hFFF;
    last_pins = 12'hFFF;
    @(negedge clk50MHz);
    @(negedge clk50MHz);
    rst_n = 1'b1;
    model_reset();

    // hex pattern A
    dwell({4'b1110, 1'b1, 7'h08}, 8);
`ifdef SEG7_CAP_HEX_EN
    check("hex_digit0", 16'(bus.digits[3:0]), 16'hA);
    check("hex_valid0", 16'(bus.valid[0]), 16'h1);
`else
    check("hex_digit0", 16'(bus.digits[3:0]), 16'h0);
    check("hex_err0", 16'(bus.err[0]), 16'h1);
`endif
    dwell(12'hFFF, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
